// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter/sequencer for the single data-memory port: legality check,
// one-cycle memory access, registered ack/err/rdata back to the grantee, round-robin on ties.
module data_mem_arbiter #(
  parameter int unsigned MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        coreReq,
  input  logic        coreWe,
  input  logic [63:0] coreAddr,
  input  logic [63:0] coreWdata,
  input  logic [2:0]  coreFunc3,
  output logic        coreAck,
  output logic        coreErr,
  output logic [63:0] coreRdata,

  input  logic        ldrReq,
  input  logic        ldrWe,
  input  logic [63:0] ldrAddr,
  input  logic [63:0] ldrWdata,
  input  logic [2:0]  ldrFunc3,
  output logic        ldrAck,
  output logic        ldrErr,
  output logic [63:0] ldrRdata,

  output logic [63:0] mr,
  output logic [63:0] mqb,
  output logic [2:0]  mfunc3,
  output logic        mwmem,
  input  logic [63:0] dmOut
);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;  // 1 = loader
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  func3_q, func3_d;
  logic        err_q, err_d;
  logic        core_ack_q, core_ack_d, core_err_q, core_err_d;
  logic        ldr_ack_q, ldr_ack_d, ldr_err_q, ldr_err_d;
  logic [63:0] core_rdata_q, core_rdata_d, ldr_rdata_q, ldr_rdata_d;

  logic        core_elig, ldr_elig, sel_ldr;
  logic [63:0] rdata_v;

  // 65-bit end address so that wrap-around past 2^64 is rejected too.
  function automatic logic access_err(input logic [63:0] addr, input logic [2:0] f3);
    logic [64:0] size;
    logic [64:0] end_addr;
    size     = 65'd1 << f3[1:0];
    end_addr = {1'b0, addr} + size;
    return (f3 == 3'b111) || ((addr & (size[63:0] - 64'd1)) != 64'd0) ||
           (end_addr > 65'(MEM_BYTES));
  endfunction

  // A port is masked during its own ack cycle so a still-held request is not re-issued.
  assign core_elig = coreReq & ~core_ack_q;
  assign ldr_elig  = ldrReq & ~ldr_ack_q;
  assign sel_ldr   = ldr_elig & (~core_elig | ~last_gnt_q);
  assign rdata_v   = (err_q | we_q) ? 64'd0 : dmOut;

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    func3_d      = func3_q;
    err_d        = err_q;
    core_ack_d   = 1'b0;
    core_err_d   = 1'b0;
    core_rdata_d = core_rdata_q;
    ldr_ack_d    = 1'b0;
    ldr_err_d    = 1'b0;
    ldr_rdata_d  = ldr_rdata_q;
    case (state_q)
      StIdle: begin
        if (core_elig || ldr_elig) begin
          gnt_d      = sel_ldr;
          last_gnt_d = sel_ldr;
          we_d       = sel_ldr ? ldrWe    : coreWe;
          addr_d     = sel_ldr ? ldrAddr  : coreAddr;
          wdata_d    = sel_ldr ? ldrWdata : coreWdata;
          func3_d    = sel_ldr ? ldrFunc3 : coreFunc3;
          err_d      = sel_ldr ? access_err(ldrAddr, ldrFunc3) :
                                 access_err(coreAddr, coreFunc3);
          state_d    = StAccess;
        end
      end
      StAccess: begin
        state_d = StIdle;
        if (gnt_q) begin
          ldr_ack_d   = 1'b1;
          ldr_err_d   = err_q;
          ldr_rdata_d = rdata_v;
        end else begin
          core_ack_d   = 1'b1;
          core_err_d   = err_q;
          core_rdata_d = rdata_v;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_gnt_q   <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      func3_q      <= 3'd0;
      err_q        <= 1'b0;
      core_ack_q   <= 1'b0;
      core_err_q   <= 1'b0;
      core_rdata_q <= 64'd0;
      ldr_ack_q    <= 1'b0;
      ldr_err_q    <= 1'b0;
      ldr_rdata_q  <= 64'd0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      func3_q      <= func3_d;
      err_q        <= err_d;
      core_ack_q   <= core_ack_d;
      core_err_q   <= core_err_d;
      core_rdata_q <= core_rdata_d;
      ldr_ack_q    <= ldr_ack_d;
      ldr_err_q    <= ldr_err_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  assign mr        = addr_q;
  assign mqb       = wdata_q;
  assign mfunc3    = func3_q;
  // Combinational with rst so a store aborted by reset never reaches the memory.
  assign mwmem     = (state_q == StAccess) & we_q & ~err_q & ~rst;
  assign coreAck   = core_ack_q;
  assign coreErr   = core_err_q;
  assign coreRdata = core_rdata_q;
  assign ldrAck    = ldr_ack_q;
  assign ldrErr    = ldr_err_q;
  assign ldrRdata  = ldr_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 2 KiB RISC-V data memory.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        coreReq, coreWe, ldrReq, ldrWe;
  logic [63:0] coreAddr, coreWdata, ldrAddr, ldrWdata;
  logic [2:0]  coreFunc3, ldrFunc3;
  logic        coreAck, coreErr, ldrAck, ldrErr;
  logic [63:0] coreRdata, ldrRdata;
  logic [63:0] mr, mqb, dmOut;
  logic [2:0]  mfunc3;
  logic        mwmem;

  logic        mem_clr;
  logic [7:0]  mem [0:2047];
  logic [63:0] raw;
  int          mw_count, core_ack_cnt, ldr_ack_cnt;
  int          vectors = 0;
  int          miscompares = 0;
  int          mw0, c0, l0, k, n, lraise;
  bit          ldone;
  logic [63:0] s_addr [4];
  logic [2:0]  s_f3 [4];
  logic [63:0] s_exp [4];

  data_mem_arbiter #(.MEM_BYTES(2048)) dut (
    .clk(clk), .rst(rst),
    .coreReq(coreReq), .coreWe(coreWe), .coreAddr(coreAddr), .coreWdata(coreWdata),
    .coreFunc3(coreFunc3), .coreAck(coreAck), .coreErr(coreErr), .coreRdata(coreRdata),
    .ldrReq(ldrReq), .ldrWe(ldrWe), .ldrAddr(ldrAddr), .ldrWdata(ldrWdata),
    .ldrFunc3(ldrFunc3), .ldrAck(ldrAck), .ldrErr(ldrErr), .ldrRdata(ldrRdata),
    .mr(mr), .mqb(mqb), .mfunc3(mfunc3), .mwmem(mwmem), .dmOut(dmOut)
  );

  always #5 clk = ~clk;

  // Little-endian memory: writes on the falling edge, combinational sized read.
  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
      mw_count     <= 0;
      core_ack_cnt <= 0;
      ldr_ack_cnt  <= 0;
    end else begin
      if (coreAck) core_ack_cnt <= core_ack_cnt + 1;
      if (ldrAck) ldr_ack_cnt <= ldr_ack_cnt + 1;
      if (mwmem) begin
        mw_count <= mw_count + 1;
        for (int i = 0; i < 8; i++)
          if (i < (1 << mfunc3[1:0]) && (mr + 64'(i)) < 64'd2048)
            mem[mr[10:0] + 11'(i)] <= mqb[8*i +: 8];
      end
    end
  end

  always_comb begin
    raw = 64'd0;
    for (int i = 0; i < 8; i++)
      if ((mr + 64'(i)) < 64'd2048) raw[8*i +: 8] = mem[mr[10:0] + 11'(i)];
    case (mfunc3)
      3'd0:    dmOut = {{56{raw[7]}}, raw[7:0]};
      3'd1:    dmOut = {{48{raw[15]}}, raw[15:0]};
      3'd2:    dmOut = {{32{raw[31]}}, raw[31:0]};
      3'd3:    dmOut = raw;
      3'd4:    dmOut = {56'd0, raw[7:0]};
      3'd5:    dmOut = {48'd0, raw[15:0]};
      3'd6:    dmOut = {32'd0, raw[31:0]};
      default: dmOut = 64'd0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " coreAck"}, 64'(coreAck), 64'd0);
    check({tag, " ldrAck"}, 64'(ldrAck), 64'd0);
    check({tag, " coreErr"}, 64'(coreErr), 64'd0);
    check({tag, " ldrErr"}, 64'(ldrErr), 64'd0);
    check({tag, " coreRdata"}, coreRdata, 64'd0);
    check({tag, " ldrRdata"}, ldrRdata, 64'd0);
    check({tag, " mr"}, mr, 64'd0);
    check({tag, " mqb"}, mqb, 64'd0);
    check({tag, " mfunc3"}, 64'(mfunc3), 64'd0);
    check({tag, " mwmem"}, 64'(mwmem), 64'd0);
  endtask

  // Single access on one port; returns in the cycle after the ack.
  task automatic access(input bit ldr, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [2:0] f3, input logic exp_err,
                        input logic [63:0] exp_rdata, input string tag);
    int  cnt, m0;
    bit  got;
    cnt = 0;
    got = 1'b0;
    m0  = mw_count;
    if (ldr) begin
      ldrReq = 1'b1; ldrWe = we; ldrAddr = addr; ldrWdata = wdata; ldrFunc3 = f3;
    end else begin
      coreReq = 1'b1; coreWe = we; coreAddr = addr; coreWdata = wdata; coreFunc3 = f3;
    end
    while (!got && cnt < 8) begin
      tick();
      cnt++;
      got = ldr ? ldrAck : coreAck;
    end
    check({tag, " latency"}, 64'(cnt), 64'd2);
    check({tag, " err"}, 64'(ldr ? ldrErr : coreErr), 64'(exp_err));
    check({tag, " rdata"}, ldr ? ldrRdata : coreRdata, exp_rdata);
    check({tag, " other ack"}, 64'(ldr ? coreAck : ldrAck), 64'd0);
    coreReq = 1'b0;
    ldrReq  = 1'b0;
    tick();
    check({tag, " writes"}, 64'(mw_count - m0), 64'((we && !exp_err) ? 1 : 0));
  endtask

  // Simultaneous core/loader loads, both held until their own ack.
  task automatic tie(input int exp_core, input int exp_ldr, input string tag);
    int cnt, cat, lat;
    cnt = 0; cat = 0; lat = 0;
    coreReq = 1'b1; coreWe = 1'b0; coreAddr = 64'h10;  coreFunc3 = 3'd3;
    ldrReq  = 1'b1; ldrWe  = 1'b0; ldrAddr  = 64'h7F8; ldrFunc3  = 3'd3;
    while ((cat == 0 || lat == 0) && cnt < 12) begin
      tick();
      cnt++;
      if (coreAck && cat == 0) begin
        cat = cnt;
        check({tag, " core rdata"}, coreRdata, 64'h1122334455667788);
        coreReq = 1'b0;
      end
      if (ldrAck && lat == 0) begin
        lat = cnt;
        check({tag, " ldr rdata"}, ldrRdata, 64'hA5A5A5A55A5A5A5A);
        ldrReq = 1'b0;
      end
    end
    check({tag, " core ack cycle"}, 64'(cat), 64'(exp_core));
    check({tag, " ldr ack cycle"}, 64'(lat), 64'(exp_ldr));
    coreReq = 1'b0;
    ldrReq  = 1'b0;
    tick();
  endtask

  initial begin
    s_addr[0] = 64'h10;  s_f3[0] = 3'd3; s_exp[0] = 64'h1122334455667788;
    s_addr[1] = 64'h17;  s_f3[1] = 3'd0; s_exp[1] = 64'h11;
    s_addr[2] = 64'h10;  s_f3[2] = 3'd4; s_exp[2] = 64'h88;
    s_addr[3] = 64'h7F8; s_f3[3] = 3'd3; s_exp[3] = 64'hA5A5A5A55A5A5A5A;

    rst = 1'b1; mem_clr = 1'b1;
    coreReq = 1'b0; coreWe = 1'b0; coreAddr = '0; coreWdata = '0; coreFunc3 = '0;
    ldrReq  = 1'b0; ldrWe  = 1'b0; ldrAddr  = '0; ldrWdata  = '0; ldrFunc3  = '0;
    tick();
    tick();
    rst = 1'b0; mem_clr = 1'b0;
    check_reset("reset");

    access(0, 1, 64'h10, 64'h1122334455667788, 3'd3, 0, 64'd0, "sd 0x10");
    access(0, 0, 64'h10, 64'd0, 3'd3, 0, 64'h1122334455667788, "ld 0x10");
    access(0, 0, 64'h17, 64'd0, 3'd0, 0, 64'h11, "lb 0x17");
    access(0, 0, 64'h10, 64'd0, 3'd4, 0, 64'h88, "lbu 0x10");
    access(0, 1, 64'h6, 64'hDEADBEEF, 3'd2, 1, 64'd0, "sw misaligned");
    access(0, 0, 64'h0, 64'd0, 3'd3, 0, 64'd0, "ld 0x0 untouched");
    access(0, 1, 64'h7F8, 64'hA5A5A5A55A5A5A5A, 3'd3, 0, 64'd0, "sd 0x7F8");
    access(0, 0, 64'h7F8, 64'd0, 3'd3, 0, 64'hA5A5A5A55A5A5A5A, "ld 0x7F8");
    access(0, 0, 64'h7FC, 64'd0, 3'd2, 0, 64'hFFFFFFFFA5A5A5A5, "lw 0x7FC");
    access(0, 0, 64'h7FC, 64'd0, 3'd3, 1, 64'd0, "ld 0x7FC");
    access(0, 0, 64'h800, 64'd0, 3'd0, 1, 64'd0, "lb 0x800");
    access(0, 0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 3'd3, 1, 64'd0, "ld wrap");
    access(0, 0, 64'h10, 64'd0, 3'd7, 1, 64'd0, "func3 7");

    // Reset during the access cycle of a store.
    access(0, 1, 64'h20, 64'h1234, 3'd3, 0, 64'd0, "sd 0x20");
    mw0 = mw_count;
    coreReq = 1'b1; coreWe = 1'b1; coreAddr = 64'h20; coreWdata = 64'hCAFE; coreFunc3 = 3'd3;
    tick();
    check("rst pre mwmem", 64'(mwmem), 64'd1);
    rst = 1'b1;
    #1;
    check("rst mwmem", 64'(mwmem), 64'd0);
    coreReq = 1'b0;
    tick();
    rst = 1'b0;
    check_reset("post rst");
    check("rst no write", 64'(mw_count - mw0), 64'd0);
    tick();
    check("rst no late ack", 64'(coreAck), 64'd0);
    access(0, 0, 64'h20, 64'd0, 3'd3, 0, 64'h1234, "ld 0x20 after rst");

    access(1, 0, 64'h10, 64'd0, 3'd3, 0, 64'h1122334455667788, "ldr ld 0x10");
    tie(2, 4, "tie1");
    access(0, 0, 64'h20, 64'd0, 3'd3, 0, 64'h1234, "core ld 0x20");
    tie(4, 2, "tie2");

    // Core streams requests, presenting new fields in each ack cycle; loader joins mid-stream.
    k = 0; n = 0; lraise = 0; ldone = 1'b0;
    c0 = core_ack_cnt; l0 = ldr_ack_cnt;
    coreReq = 1'b1; coreWe = 1'b0; coreAddr = s_addr[0]; coreFunc3 = s_f3[0];
    while ((k < 4 || !ldone) && n < 40) begin
      tick();
      n++;
      if (coreAck && k < 4) begin
        check($sformatf("stream%0d rdata", k), coreRdata, s_exp[k]);
        k++;
        if (k < 4) begin
          coreAddr = s_addr[k]; coreFunc3 = s_f3[k];
        end else begin
          coreReq = 1'b0;
        end
      end
      if (ldrAck && !ldone) begin
        check("stream ldr rdata", ldrRdata, 64'h1234);
        check("stream ldr within 4", 64'((n - lraise) <= 4), 64'd1);
        ldrReq = 1'b0;
        ldone  = 1'b1;
      end
      if (n == 3) begin
        ldrReq = 1'b1; ldrWe = 1'b0; ldrAddr = 64'h20; ldrFunc3 = 3'd3;
        lraise = n;
      end
    end
    check("stream done", 64'(k == 4 && ldone), 64'd1);
    coreReq = 1'b0;
    ldrReq  = 1'b0;
    tick();
    tick();
    check("stream core acks", 64'(core_ack_cnt - c0), 64'd4);
    check("stream ldr acks", 64'(ldr_ack_cnt - l0), 64'd1);
    check("core rdata held", coreRdata, 64'hA5A5A5A55A5A5A5A);
    check("ldr rdata held", ldrRdata, 64'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the on-chip data memory in the memory-access stage. It shares the single memory port between the core load/store path and the program-loader/debug path. Each access is checked for legality, driven to the memory for exactly one cycle, and completed with a registered acknowledge and read data. Tied requests are granted round-robin.

## Interface
- MEM_BYTES, 2048: size of the data memory in bytes; used for the bounds check.
- clk  in  1  clock; memory writes land on its falling edge, all arbiter state on its rising edge.
- rst  in  1  synchronous, active-high reset.
- coreReq  in  1  core access request; held with its fields until coreAck.
- coreWe  in  1  1 = store, 0 = load.
- coreAddr  in  64  byte address.
- coreWdata  in  64  store data, LSB-aligned.
- coreFunc3  in  3  RISC-V funct3 size/sign code.
- coreAck  out  1  one-cycle completion pulse.
- coreErr  out  1  valid with coreAck; access rejected.
- coreRdata  out  64  load result, valid with coreAck.
- ldrReq, ldrWe, ldrAddr, ldrWdata, ldrFunc3, ldrAck, ldrErr, ldrRdata  same as core*, for the loader/debug requester.
- mr  out  64  memory address.
- mqb  out  64  memory write data.
- mfunc3  out  3  memory access type.
- mwmem  out  1  memory write enable.
- dmOut  in  64  combinational memory read data.

## Operation
- FSM states: IDLE and ACCESS.
- IDLE:
  - Eligible requester = req high and its ack not currently high (prevents re-issue in the ack cycle).
  - One eligible: grant it.
  - Both eligible: grant the one not recorded in lastGnt.
  - On grant: latch we, addr, wdata, func3 and the grantee id; set lastGnt = grantee; compute errLatched; go to ACCESS.
  - No eligible requester: stay in IDLE.
- Error conditions, computed at latch time:
  - func3 == 3'b111.
  - addr not aligned to the access size (size = 1 << func3[1:0]).
  - addr + size > MEM_BYTES, evaluated in 65-bit arithmetic so wrap-around counts as an error.
- ACCESS:
  - mr, mqb, mfunc3 = latched values.
  - mwmem = latchedWe & ~errLatched & ~rst, combinational, so a rejected or reset-aborted store never writes.
  - At the rising edge ending ACCESS, go to IDLE and register the result to the grantee:
    - ack = 1.
    - err = errLatched.
    - rdata = errLatched ? 0 : (latchedWe ? 0 : dmOut).
- Outside ACCESS: mwmem = 0; mr/mqb/mfunc3 hold their last latched values.
- Ack, err and rdata of the non-granted port stay 0 / hold.
- rdata holds its value until that port's next ack.
- Reset values:
  - state = IDLE.
  - lastGnt = loader, so the core wins the first tie.
  - All ack and err outputs 0; both rdata outputs 0.
  - Latched fields 0, so mr = mqb = 0 and mfunc3 = 0; mwmem = 0.

## Timing
- Request sampled at rising edge N → ACCESS during cycle N+1 → ack high during cycle N+2. Latency is 2 cycles.
- Peak throughput: one access per 2 cycles.
- Back-to-back: a second requester pending at edge N+2 enters ACCESS in cycle N+3.
- The store commits on the falling edge inside the ACCESS cycle. Read data is sampled at the end of the same cycle.
- The requester must hold all fields stable from raising req until the cycle ack is high. It may drop req or present a new request starting the cycle after ack.
- rst high in any cycle: the next state is the reset state, no ack is issued for an in-flight access, and any write in that cycle is suppressed.

## Test plan
- Core store then load: coreWe=1, addr 0x10, func3 3, wdata 0x1122334455667788 → coreAck at +2, err 0. Then load with func3 3 → coreRdata 0x1122334455667788. Load with func3 0 at 0x17 → 0x0000000000000011. Load with func3 4 at 0x10 → 0x88.
- Simultaneous coreReq and ldrReq loads, both held → core acked first (cycle +2), loader acked at +4. Repeat the tie → loader first.
- Misaligned and out-of-range accesses:
  - Store func3 2 at addr 0x6 → ack with err=1, mwmem never high, memory unchanged.
  - func3 3 at 0x7F8 is legal.
  - func3 3 at 0x7FC → err=1.
  - addr 0xFFFFFFFFFFFFFFF8 → err=1.
- func3 7 load → err=1, rdata 0.
- rst asserted in the ACCESS cycle of a store to 0x20 → no ack, mwmem low, a later load of 0x20 returns the prior value. All outputs equal their reset values the cycle after rst.
- Continuous coreReq with new fields each ack → one ack every 2 cycles, no duplicate grant during ack cycles. ldrReq raised mid-stream is granted within 4 cycles.
